// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Brief    : UART transmit frame sequencer (start, 8 data LSB-first, optional
//            parity, stop). Define UART_TX_STOP2_EN for two stop bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic [1:0] parity_type,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int                c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_par_en;
    logic               r_par_bit;
    logic               r_tx_out;

    logic               w_bit_end;
    logic               w_last_stop;

    assign w_bit_end = (r_cnt == c_CNT_LAST);

    // In STOP the bit index doubles as the stop-bit counter.
`ifdef UART_TX_STOP2_EN
    assign w_last_stop = (r_bit_idx == 3'd1);
`else
    assign w_last_stop = 1'b1;
`endif

    assign tx_ready = (r_state == ST_IDLE);
    assign tx_busy  = (r_state != ST_IDLE);
    assign tx_done  = (r_state == ST_STOP) && w_bit_end && w_last_stop;
    assign tx_out   = r_tx_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx_out  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx_out <= 1'b1;
                    if (tx_valid) begin
                        r_shift   <= tx_data;
                        r_par_en  <= |parity_type;
                        r_par_bit <= parity_type[1] ? ~(^tx_data) : (^tx_data);
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_tx_out  <= 1'b0;
                        r_state   <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_cnt    <= '0;
                        r_tx_out <= r_shift[0];
                        r_state  <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            if (r_par_en) begin
                                r_tx_out <= r_par_bit;
                                r_state  <= ST_PARITY;
                            end else begin
                                r_tx_out <= 1'b1;
                                r_state  <= ST_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx_out  <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_tx_out  <= 1'b1;
                        r_state   <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    r_tx_out <= 1'b1;
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_last_stop) begin
                            r_bit_idx <= 3'd0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                default: begin
                    r_cnt     <= '0;
                    r_bit_idx <= 3'd0;
                    r_tx_out  <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// Bench for uart_tx_ctrl: per-cycle comparison against a queue-based frame
// model, plus literal expectations for known bytes.
module tb_uart_tx_ctrl;

    localparam int N = 4;
`ifdef UART_TX_STOP2_EN
    localparam int S         = 2;
    localparam int c_DONE_NP = 44;
    localparam int c_DONE_P  = 48;
`else
    localparam int S         = 1;
    localparam int c_DONE_NP = 40;
    localparam int c_DONE_P  = 44;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] parity_type;
    logic       tx_ready;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_ctrl #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .parity_type(parity_type),
        .tx_ready   (tx_ready),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: on acceptance the whole frame is expanded into one line level per
    // clock cycle; each later cycle consumes one entry.
    bit   m_q[$];
    bit   frame_bits[$];
    logic m_out = 1'b1, m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0;
    bit   chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
        end else if (m_q.size() == 0) begin
            if (tx_valid) begin
                frame_bits.delete();
                frame_bits.push_back(1'b0);
                for (int i = 0; i < 8; i++) frame_bits.push_back(tx_data[i]);
                if (parity_type == 2'b01)
                    frame_bits.push_back(($countones(tx_data) % 2) == 1);
                else if (parity_type != 2'b00)
                    frame_bits.push_back(($countones(tx_data) % 2) == 0);
                for (int i = 0; i < S; i++) frame_bits.push_back(1'b1);
                foreach (frame_bits[k])
                    for (int j = 0; j < N; j++) m_q.push_back(frame_bits[k]);
            end
        end else begin
            void'(m_q.pop_front());
        end
        if (m_q.size() == 0) begin
            m_out = 1'b1; m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            m_out = m_q[0]; m_ready = 1'b0; m_busy = 1'b1; m_done = (m_q.size() == 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_out",   int'(tx_out),   int'(m_out));
            check("tx_ready", int'(tx_ready), int'(m_ready));
            check("tx_busy",  int'(tx_busy),  int'(m_busy));
            check("tx_done",  int'(tx_done),  int'(m_done));
        end
    end

    // Sends one byte; samples mid-bit levels and the cycle of tx_done relative
    // to the acceptance edge. Inputs are scrambled while the frame is in flight.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] pt, input bit hold,
                             output int wait_cyc, output int done_cyc,
                             output logic [11:0] bits);
        wait_cyc = 0;
        while (!tx_ready && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!tx_ready) begin
            n_tests++; n_fail++;
            $display("FAIL ready_timeout: got tx_ready=0, expected 1 within 200 cycles");
        end
        tx_valid = 1'b1; tx_data = d; parity_type = pt;
        @(posedge clk);
        bits = '0;
        done_cyc = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if ((c % N) == 2 && (c / N) < 12) bits[c / N] = tx_out;
            if (tx_done) begin
                done_cyc = c;
                if (!hold) tx_valid = 1'b0;
                break;
            end
            tx_data     = 8'($urandom);
            parity_type = 2'($urandom);
            tx_valid    = hold ? 1'b1 : 1'($urandom);
        end
        if (done_cyc == 0) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: got no tx_done, expected one within 100 cycles");
            tx_valid = 1'b0;
        end
    endtask

    task automatic reset_mid_frame();
        int   w;
        bit   saw_done;
        w = 0;
        while (!tx_ready && w < 200) begin @(negedge clk); w++; end
        tx_valid = 1'b1; tx_data = 8'h3C; parity_type = 2'b01;
        @(posedge clk);
        tx_valid = 1'b0;
        saw_done = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (tx_done) saw_done = 1'b1;
            tx_data = 8'($urandom); parity_type = 2'($urandom);
        end
        check("bit3_before_rst", int'(tx_out), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_out",  int'(tx_out),  1);
        check("rst_mid_busy", int'(tx_busy), 0);
        check("rst_mid_done", int'(tx_done), 0);
        check("rst_mid_no_done_before", int'(saw_done), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", int'(tx_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          wc, dc;
        logic [11:0] bits;
        logic [1:0]  pt;
        logic        p;

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; parity_type = 2'b00;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_out",   int'(tx_out),   1);
        check("reset_ready", int'(tx_ready), 1);
        check("reset_busy",  int'(tx_busy),  0);
        check("reset_done",  int'(tx_done),  0);

        // valid asserted during reset must not be accepted
        rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h55;
        repeat (3) @(negedge clk);
        rst = 1'b0; tx_valid = 1'b0;
        @(negedge clk);
        check("rst_valid_busy",  int'(tx_busy),  0);
        check("rst_valid_ready", int'(tx_ready), 1);

        run_frame(8'hA5, 2'b00, 1'b0, wc, dc, bits);
        check("a5_none_done_cycle", dc, c_DONE_NP);
        check("a5_none_bits", int'(bits[9:0]), int'({1'b1, 8'hA5, 1'b0}));

        for (int k = 1; k <= 3; k++) begin
            pt = 2'(k);
            p  = (k == 1) ? 1'b0 : 1'b1;
            run_frame(8'hA5, pt, 1'b0, wc, dc, bits);
            check("a5_par_done_cycle", dc, c_DONE_P);
            check("a5_par_bits", int'(bits[10:0]), int'({1'b1, p, 8'hA5, 1'b0}));
        end

        run_frame(8'h01, 2'b10, 1'b1, wc, dc, bits);
        check("b2b_par0", int'(bits[9]), 0);
        tx_data = 8'hFF; parity_type = 2'b10;
        run_frame(8'hFF, 2'b10, 1'b1, wc, dc, bits);
        tx_valid = 1'b0;
        check("b2b_gap", wc, 1);
        check("b2b_par1", int'(bits[9]), 1);
        check("b2b_done_cycle", dc, c_DONE_P);

        reset_mid_frame();
        run_frame(8'hC3, 2'b01, 1'b0, wc, dc, bits);
        check("after_rst_done_cycle", dc, c_DONE_P);
        check("after_rst_bits", int'(bits[10:0]), int'({1'b1, 1'b0, 8'hC3, 1'b0}));

        for (int r = 0; r < 40; r++) begin
            run_frame(8'($urandom), 2'($urandom), 1'($urandom), wc, dc, bits);
            tx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (60) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
